// File: rtl/dec_sci_normalizer.sv
// Decimal scientific-notation normaliser.
// Takes a binary integer part and a fraction scaled by 10^FRAC_DIGITS, and
// scales the combined value one decade per cycle until exactly one nonzero
// digit sits left of the decimal point. It then reports the lead digit, the
// next FRAC_DIGITS digits, the exponent magnitude and an ASCII sign.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE. out_valid stays 1, with its data
// stable, until an edge with out_ready=1. Neither side's valid depends
// combinationally on the other side's ready.
module dec_sci_normalizer #(
  parameter int INT_W       = 24,
  parameter int FRAC_DIGITS = 7,
  parameter int FRAC_W      = 24,
  parameter int EXP_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INT_W-1:0]  int_in,
  input  logic [FRAC_W-1:0] frac_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        lead_digit,
  output logic [FRAC_W-1:0] tail,
  output logic [EXP_W-1:0]  exp_mag,
  output logic [7:0]        exp_sign,
  output logic              zero,
  output logic              inexact,
  output logic              err
);

  localparam int VW = INT_W + FRAC_W;
  localparam int XW = EXP_W + 1;

  function automatic logic [VW-1:0] pow10(input int n);
    logic [VW-1:0] r;
    r = VW'(1);
    for (int i = 0; i < n; i++) r = r * VW'(10);
    return r;
  endfunction

  // S is the weight of the units digit. S10 is the first value with two
  // integer digits.
  localparam logic [VW-1:0] S   = pow10(FRAC_DIGITS);
  localparam logic [VW-1:0] S10 = pow10(FRAC_DIGITS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nx;

  logic [VW-1:0]        v_r;
  logic signed [XW-1:0] exp_r;
  logic                 sticky_r;
  logic                 err_r;

  logic                 norm_done;
  logic [XW-1:0]        exp_abs;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The value is normalised when it is zero or has exactly one integer digit.
  assign norm_done = (v_r == '0) || ((v_r >= S) && (v_r < S10));
  assign exp_abs   = exp_r[XW-1] ? XW'(-exp_r) : XW'(exp_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = NORM;
      NORM:    if (norm_done) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Working datapath: load on accept, one decade step per NORM cycle, and
  // capture the result on the cycle NORM finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r        <= '0;
      exp_r      <= '0;
      sticky_r   <= 1'b0;
      err_r      <= 1'b0;
      lead_digit <= '0;
      tail       <= '0;
      exp_mag    <= '0;
      exp_sign   <= 8'h2B;
      zero       <= 1'b0;
      inexact    <= 1'b0;
      err        <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      exp_r    <= '0;
      sticky_r <= 1'b0;
      if (VW'(frac_in) >= S) begin
        // An out-of-range fraction is reported as an error with a zero value.
        v_r   <= '0;
        err_r <= 1'b1;
      end else begin
        v_r   <= VW'(int_in) * S + VW'(frac_in);
        err_r <= 1'b0;
      end
    end else if (state == NORM) begin
      if (norm_done) begin
        lead_digit <= 4'(v_r / S);
        tail       <= FRAC_W'(v_r % S);
        exp_mag    <= EXP_W'(exp_abs);
        exp_sign   <= exp_r[XW-1] ? 8'h2D : 8'h2B;
        zero       <= (v_r == '0);
        inexact    <= sticky_r;
        err        <= err_r;
      end else if (v_r >= S10) begin
        v_r      <= v_r / VW'(10);
        sticky_r <= sticky_r | ((v_r % VW'(10)) != '0);
        exp_r    <= exp_r + XW'(1);
      end else begin
        v_r   <= v_r * VW'(10);
        exp_r <= exp_r - XW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dec_sci_normalizer.sv
// Self-checking bench for dec_sci_normalizer: directed vector table, random
// operands against a digit-counting reference model, plus backpressure and
// reset-during-operation sequences.
module tb_dec_sci_normalizer;

  localparam longint unsigned S = 64'd10000000;
  localparam int RW = 47;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] int_in;
  logic [23:0] frac_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  lead_digit;
  logic [23:0] tail;
  logic [7:0]  exp_mag;
  logic [7:0]  exp_sign;
  logic        zero;
  logic        inexact;
  logic        err;

  int checks;
  int failures;
  logic [RW-1:0] exp_q[$];

  dec_sci_normalizer #(
    .INT_W(24), .FRAC_DIGITS(7), .FRAC_W(24), .EXP_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .int_in(int_in), .frac_in(frac_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .lead_digit(lead_digit), .tail(tail),
    .exp_mag(exp_mag), .exp_sign(exp_sign),
    .zero(zero), .inexact(inexact), .err(err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] i;
    logic [23:0] f;
    logic [3:0]  lead;
    logic [23:0] tl;
    logic [7:0]  mag;
    logic [7:0]  sign;
    logic        z;
    logic        inx;
    logic        e;
    int          lat;
  } vec_t;

  function automatic logic [RW-1:0] pack(input logic [3:0] l, input logic [23:0] t,
                                         input logic [7:0] m, input logic [7:0] s,
                                         input logic z, input logic x, input logic e);
    return {l, t, m, s, z, x, e};
  endfunction

  function automatic logic [RW-1:0] dut_res();
    return {lead_digit, tail, exp_mag, exp_sign, zero, inexact, err};
  endfunction

  // Reference model: count the decimal digits of the value to find the
  // exponent directly, then shift by a power of ten in one go.
  task automatic model(input logic [23:0] i, input logic [23:0] f,
                       output logic [RW-1:0] res, output int lat);
    longint unsigned v, p, sig;
    int d, e;
    logic inx;
    if (64'(f) >= S) begin
      res = pack(4'd0, 24'd0, 8'd0, 8'h2B, 1'b1, 1'b0, 1'b1);
      lat = 1;
      return;
    end
    v = 64'(i) * S + 64'(f);
    if (v == 0) begin
      res = pack(4'd0, 24'd0, 8'd0, 8'h2B, 1'b1, 1'b0, 1'b0);
      lat = 1;
      return;
    end
    d = 0;
    p = v;
    while (p > 0) begin
      p = p / 10;
      d++;
    end
    e = d - 8;
    p = 1;
    if (e >= 0) begin
      repeat (e) p = p * 10;
      sig = v / p;
      inx = (v % p) != 0;
    end else begin
      repeat (-e) p = p * 10;
      sig = v * p;
      inx = 1'b0;
    end
    res = pack(4'(sig / S), 24'(sig % S), 8'(e < 0 ? -e : e),
               (e < 0) ? 8'h2D : 8'h2B, 1'b0, inx, 1'b0);
    lat = (e < 0 ? -e : e) + 1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Driver: present one operand, wait for the result, optionally hold
  // backpressure for some cycles, then accept the result.
  task automatic run_op(input logic [23:0] i, input logic [23:0] f,
                        input logic [RW-1:0] res, input int lat_req, input int hold);
    int lat;
    bit got;
    logic [RW-1:0] expv;
    exp_q.push_back(res);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    int_in = i;
    frac_in = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (lat < 200 && !got) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) got = 1'b1;
    end
    expv = exp_q.pop_front();
    if (!got) begin
      failures++;
      checks++;
      $display("FAIL timeout: out_valid not seen for int=%0d frac=%0d", i, f);
      return;
    end
    check("latency", 64'(lat), 64'(lat_req));
    check("result", 64'(dut_res()), 64'(expv));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      int_in = 24'($urandom);
      frac_in = 24'($urandom_range(0, 9999999));
      @(posedge clk);
      #1;
      check("hold_valid", 64'({out_valid, in_ready}), 64'(2'b10));
      check("hold_data", 64'(dut_res()), 64'(expv));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("release", 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  vec_t vecs[11];
  logic [RW-1:0] rres;
  int rlat;
  logic [23:0] ri, rf;
  bit seen;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    int_in = '0;
    frac_in = '0;

    vecs[0]  = '{24'd10,       24'd5000000,  4'd1, 24'd500000,  8'd1, 8'h2B, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{24'd0,        24'd5000000,  4'd5, 24'd0,       8'd1, 8'h2D, 1'b0, 1'b0, 1'b0, 2};
    vecs[2]  = '{24'd1062,     24'd0,        4'd1, 24'd620000,  8'd3, 8'h2B, 1'b0, 1'b0, 1'b0, 4};
    vecs[3]  = '{24'd1234567,  24'd1,        4'd1, 24'd2345670, 8'd6, 8'h2B, 1'b0, 1'b1, 1'b0, 7};
    vecs[4]  = '{24'd0,        24'd0,        4'd0, 24'd0,       8'd0, 8'h2B, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{24'd0,        24'd10000000, 4'd0, 24'd0,       8'd0, 8'h2B, 1'b1, 1'b0, 1'b1, 1};
    vecs[6]  = '{24'd1,        24'd0,        4'd1, 24'd0,       8'd0, 8'h2B, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{24'd0,        24'd1,        4'd1, 24'd0,       8'd7, 8'h2D, 1'b0, 1'b0, 1'b0, 8};
    vecs[8]  = '{24'd9,        24'd9999999,  4'd9, 24'd9999999, 8'd0, 8'h2B, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{24'd16777215, 24'd9999999,  4'd1, 24'd6777215, 8'd7, 8'h2B, 1'b0, 1'b1, 1'b0, 8};
    vecs[10] = '{24'd0,        24'd9999999,  4'd9, 24'd9999990, 8'd1, 8'h2D, 1'b0, 1'b0, 1'b0, 2};

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_hs", 64'({in_ready, out_valid}), 64'(2'b10));
    check("reset_data", 64'(dut_res()), 64'(pack(4'd0, 24'd0, 8'd0, 8'h2B, 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int n = 0; n < 11; n++) begin
      run_op(vecs[n].i, vecs[n].f,
             pack(vecs[n].lead, vecs[n].tl, vecs[n].mag, vecs[n].sign,
                  vecs[n].z, vecs[n].inx, vecs[n].e),
             vecs[n].lat, 0);
    end

    // Backpressure for 5 cycles with in_valid asserted meanwhile
    run_op(24'd10, 24'd5000000, pack(4'd1, 24'd500000, 8'd1, 8'h2B, 1'b0, 1'b0, 1'b0), 2, 5);

    // Random operands against the reference model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: ri = 24'd0;
        1: ri = 24'($urandom_range(0, 99));
        2: ri = 24'($urandom);
        default: ri = 24'($urandom_range(0, 9));
      endcase
      if ($urandom_range(0, 15) == 0) rf = 24'($urandom_range(10000000, 16777215));
      else if ($urandom_range(0, 3) == 0) rf = 24'($urandom_range(0, 99));
      else rf = 24'($urandom_range(0, 9999999));
      model(ri, rf, rres, rlat);
      run_op(ri, rf, rres, rlat, $urandom_range(0, 2));
    end

    // Reset in the middle of normalisation discards the operation
    @(negedge clk);
    int_in = 24'd16777215;
    frac_in = 24'd9999999;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_hs", 64'({in_ready, out_valid}), 64'(2'b10));
    check("midreset_data", 64'(dut_res()), 64'(pack(4'd0, 24'd0, 8'd0, 8'h2B, 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midreset_no_output", 64'(seen), 64'd0);

    // Recovery after reset
    run_op(24'd1062, 24'd0, pack(4'd1, 24'd620000, 8'd3, 8'h2B, 1'b0, 1'b0, 1'b0), 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dec_sci_normalizer.md
Name: dec_sci_normalizer

Overview:
- Multi-cycle, parametrised normaliser. Converts a binary integer part plus a decimal-scaled fraction into decimal scientific notation: lead digit, tail digits, exponent magnitude and ASCII exponent sign.
- Sits after the float-to-fixed split stage in the FLOAT_TO_DECIMAL path and feeds the ASCII formatter.
- Supports negative exponents with arbitrary leading zeros.
- Bounds precision to FRAC_DIGITS+1 significant digits and reports truncation through a sticky inexact flag.
- Uses a valid/ready handshake on both sides.

Parameters:
- INT_W, 24, width of binary integer part input.
- FRAC_DIGITS, 7, number of decimal digits in fraction input; fraction value = frac_in / 10^FRAC_DIGITS.
- FRAC_W, 24, width of fraction input and tail output; requires 10^FRAC_DIGITS < 2^FRAC_W.
- EXP_W, 8, width of exponent magnitude output.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block idle, can accept.
- int_in  in  INT_W  binary integer part.
- frac_in  in  FRAC_W  fraction digits, scaled by 10^FRAC_DIGITS.
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  consumer accepts result.
- lead_digit  out  4  leading significant digit, 0..9.
- tail  out  FRAC_W  following FRAC_DIGITS digits as an integer, 0..10^FRAC_DIGITS-1.
- exp_mag  out  EXP_W  magnitude of decimal exponent.
- exp_sign  out  8  ASCII sign: 8'h2B '+' for exp>=0, 8'h2D '-' for exp<0.
- zero  out  1  value is exactly zero.
- inexact  out  1  nonzero digits dropped during scaling.
- err  out  1  frac_in >= 10^FRAC_DIGITS; result forced to zero.

Behaviour:
- Let S = 10^FRAC_DIGITS. The working register V is INT_W+FRAC_W bits wide. The exponent register is signed, EXP_W+1 bits.
- States:
  - IDLE: in_ready=1.
  - NORM: one scaling step per cycle.
  - DONE: out_valid=1.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, lead_digit=0, tail=0, exp_mag=0, exp_sign=8'h2B, zero=0, inexact=0, err=0.
  - Reset during NORM or DONE discards the operation with no output.
- Accept: on an edge with state IDLE and in_valid=1.
  - V <= int_in*S + frac_in; exp <= 0; sticky <= 0.
  - If frac_in >= S: V <= 0 and err_r <= 1.
  - State goes to NORM.
- NORM, each cycle, in priority order:
  - V == 0: go to DONE.
  - V >= 10*S: V <= V/10; sticky |= (V%10 != 0); exp++.
  - V < S: V <= V*10; exp--.
  - Otherwise (S <= V < 10*S): go to DONE.
- On the transition to DONE, register the outputs:
  - lead_digit = V/S; tail = V%S.
  - exp_mag = |exp|; exp_sign = '-' iff exp<0.
  - zero = (V==0); inexact = sticky; err = err_r.
- Zero result: lead_digit=0, tail=0, exp_mag=0, exp_sign='+'.
- Latency: out_valid rises steps+1 cycles after the accept edge, where steps is the number of scaling operations (zero/err: 1 cycle).
- DONE:
  - Outputs held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, out_valid goes to 0 and state goes to IDLE.
  - Output data registers keep their last value until the next result.
  - Earliest next accept is the edge after returning to IDLE; no overlap.
- in_valid is ignored outside IDLE. in_ready = (state==IDLE).
- Scaling direction is monotonic per operation: only divides or only multiplies, never both.
- Maximum steps: INT_W-digit integer down, or FRAC_DIGITS up. exp_mag must never overflow for legal parameters.
- Division and modulo by 10 and S are constant-divisor combinational logic inside the registered datapath.

Test Plan:
- int_in=10, frac_in=5000000 (1.05e1) -> V=105000000; one divide; lead_digit=1, tail=500000, exp_mag=1, exp_sign=8'h2B, inexact=0. out_valid 2 cycles after accept.
- int_in=0, frac_in=5000000 -> one multiply; lead_digit=5, tail=0, exp_mag=1, exp_sign=8'h2D, latency 2.
- int_in=1062, frac_in=0 -> 3 divides; lead_digit=1, tail=620000, exp_mag=3, exp_sign='+', inexact=0, latency 4.
- int_in=1234567, frac_in=1 -> 6 divides; lead_digit=1, tail=2345670, exp_mag=6, inexact=1.
- int_in=0, frac_in=0 -> zero=1, outputs 0/'+', latency 1; then frac_in=10000000 -> err=1, zero=1, latency 1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0, new in_valid ignored.
  - Then out_ready=1: out_valid falls, in_ready rises next cycle.
  - Separately, assert rst_n=0 mid-NORM on int_in=16777215, frac_in=9999999: out_valid never rises, all outputs return to reset values.
